// File: rtl/ls_component_if.sv
//------------------------------------------------------------------------------
// ls_component_if
//   Bundle of the load-size unit's request/response signals.
//
//   Signals:
//     start      control unit -> unit : request a load (sampled only in IDLE)
//     controleLS control unit -> unit : size select 00 word, 01 byte,
//                                       10 half, 11 word
//     mem_data   memory       -> unit : memory read word
//     mem_rd     unit -> memory       : one-cycle read strobe per load
//     ls_out     unit -> regfile mux  : extracted load result
//     busy       unit -> control unit : high while a load is in flight
//     done       unit -> control unit : one-cycle pulse, ls_out updated
//
//   Modports:
//     slave  : the load-size unit itself
//     master : whoever sequences it (control unit / memory model)
//
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ls_component_if;
  logic        start;
  logic [1:0]  controleLS;
  logic [31:0] mem_data;
  logic        mem_rd;
  logic [31:0] ls_out;
  logic        busy;
  logic        done;

  modport slave (
    input  start,
    input  controleLS,
    input  mem_data,
    output mem_rd,
    output ls_out,
    output busy,
    output done
  );

  modport master (
    output start,
    output controleLS,
    output mem_data,
    input  mem_rd,
    input  ls_out,
    input  busy,
    input  done
  );
endinterface

`default_nettype wire

// File: rtl/ls_component.sv
//------------------------------------------------------------------------------
// ls_component
//   Load-size unit. On an accepted start it strobes mem_rd for one cycle,
//   waits MEM_LATENCY cycles for the memory word, extracts a word, halfword
//   or byte from it and presents the result on ls_out with a one-cycle done
//   pulse.
//
//   Ports:
//     clk    : system clock, rising edge
//     reset  : asynchronous, active-low reset
//     bus    : ls_component_if.slave (start, controleLS, mem_data in;
//              mem_rd, ls_out, busy, done out)
//
//   Parameters:
//     MEM_LATENCY : cycles from the end of the mem_rd cycle to valid
//                   mem_data, 1..7
//     CNT_W       : latency counter width, must hold MEM_LATENCY
//
//   Build option:
//     LS_SIGN_EXT_EN : when defined, byte and half results are sign-extended;
//                      otherwise they are zero-extended. Timing is identical.
//
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ls_component #(
  parameter int MEM_LATENCY = 2,
  parameter int CNT_W       = 3
) (
  input  logic           clk,
  input  logic           reset,
  ls_component_if.slave  bus
);

  // State encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Size select encoding
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;

  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       size;
  logic [31:0]      result;
  logic [31:0]      extracted;

  // Lane extraction from the latched size. Lanes are fixed at [7:0] and
  // [15:0]; there is no address-based shifting, mirroring the store side.
  always_comb begin
    extracted = bus.mem_data;
    case (size)
`ifdef LS_SIGN_EXT_EN
      SZ_BYTE: extracted = {{24{bus.mem_data[7]}}, bus.mem_data[7:0]};
      SZ_HALF: extracted = {{16{bus.mem_data[15]}}, bus.mem_data[15:0]};
`else
      SZ_BYTE: extracted = {24'h0, bus.mem_data[7:0]};
      SZ_HALF: extracted = {16'h0, bus.mem_data[15:0]};
`endif
      default: extracted = bus.mem_data;  // 00 word, 11 treated as word
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.start) state_next = S_READ;
      S_READ:  state_next = S_WAIT;
      S_WAIT:  if (cnt == CNT_ONE) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      size   <= 2'b00;
      result <= 32'h0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          // Size is latched only on acceptance, so later controleLS
          // changes cannot disturb the load in flight.
          if (bus.start) size <= bus.controleLS;
        end
        S_READ: cnt <= LAT_INIT;
        S_WAIT: begin
          if (cnt == CNT_ONE) result <= extracted;
          else                cnt    <= cnt - CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  // Strobes decode from the state register only; an asynchronous reset
  // therefore drops them immediately.
  assign bus.mem_rd = (state == S_READ);
  assign bus.busy   = (state != S_IDLE);
  assign bus.done   = (state == S_DONE);
  assign bus.ls_out = result;

endmodule

`default_nettype wire

// File: doc/ls_component.md
Name: ls_component

Overview:
- Load-size unit: the read-side counterpart of the store-size merge path.
- On `start`, it issues a one-cycle memory read strobe and waits a fixed memory latency.
- It then captures the memory read word and extracts a word, halfword or byte into `ls_out` for register writeback.
- It sits between the memory data output and the register-file write-data mux, and is sequenced by the control unit through `start`/`done`.

Parameters:
- MEM_LATENCY, 2, cycles from the end of the `mem_rd` cycle to valid `mem_data`; legal range 1..7.
- CNT_W, 3, width of the latency counter; must hold MEM_LATENCY.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a load; sampled only in IDLE.
- controleLS  input  2  size select: 00 word, 01 byte, 10 half, 11 reserved (treated as word).
- mem_data  input  32  memory read data.
- mem_rd  output  1  memory read strobe, one cycle per accepted request.
- ls_out  output  32  extracted load result.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; `ls_out` is valid and updated in this cycle.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; `mem_rd`, `busy`, `done` = 0; `ls_out`=32'h0; counter=0; latched size=00. A mid-operation reset aborts immediately, and `mem_rd` drops without waiting for a clock edge.
- FSM states: IDLE, READ, WAIT, DONE. All outputs are registered or decoded from state only; none depend combinationally on `start`.
- IDLE: at an edge E with start=1, latch `controleLS` and go to READ. With start=0, stay in IDLE.
- READ: `mem_rd`=1 for exactly this cycle. At the next edge, load counter=MEM_LATENCY and go to WAIT.
- WAIT: at each edge, if counter==1, capture the extracted `mem_data` into `ls_out` and go to DONE; otherwise decrement the counter.
- DONE: `done`=1 for one cycle, then go to IDLE at the next edge.
- Latency: `done` is high from edge E+MEM_LATENCY+1 to edge E+MEM_LATENCY+2. Back-to-back issue is possible, with the next start sampled at E+MEM_LATENCY+3 or later.
- Extraction uses the latched size, never the live `controleLS`:
  - word: `ls_out` = mem_data.
  - byte: `ls_out` = {24'h0, mem_data[7:0]}.
  - half: `ls_out` = {16'h0, mem_data[15:0]}.
  - 11: same as word.
- No address-based lane shifting: the byte and half lanes are always bits [7:0] and [15:0], matching the store-size side.
- `ls_out` holds its value between captures. It changes only on the WAIT→DONE edge or on reset.
- `start` while busy is ignored: no queuing, no effect on the latched size.
- `controleLS` changes after acceptance have no effect on the in-flight load.
- An illegal or unreachable state encoding returns to IDLE on the next edge with all strobes low.

Optional Feature:
- LS_SIGN_EXT_EN defined: byte and half results are sign-extended, i.e. {{24{mem_data[7]}}, mem_data[7:0]} and {{16{mem_data[15]}}, mem_data[15:0]}. Word is unchanged.
- LS_SIGN_EXT_EN undefined: zero-extension exactly as in Behaviour.
- Timing and FSM are identical in both builds.

Test Plan:
- Reset: hold reset=0 with start=1 and mem_data=32'hFFFFFFFF for 3 cycles -> `ls_out`=0, `mem_rd`=`busy`=`done`=0 throughout; release, then idle with start=0 -> outputs stay 0.
- Word load, MEM_LATENCY=2: start at edge E with controleLS=00 and mem_data=32'hA1B2C3F4 -> `mem_rd`=1 only in cycle E..E+1; `done`=1 only in E+3..E+4; `ls_out`=32'hA1B2C3F4; `busy` high E..E+4.
- Byte and half, mem_data=32'hA1B2C3F4:
  - controleLS=01 -> `ls_out`=32'h000000F4 (32'hFFFFFFF4 with LS_SIGN_EXT_EN).
  - controleLS=10 -> `ls_out`=32'h0000C3F4 (32'hFFFFC3F4 with LS_SIGN_EXT_EN).
  - controleLS=11 -> `ls_out`=32'hA1B2C3F4.
- Busy/size hold: start with byte; toggle start=1 and controleLS=00 every cycle while busy -> exactly one `mem_rd` pulse, result 32'h000000F4, and the next load is accepted only from IDLE.
- Mid-operation reset: assert reset=0 during WAIT -> `mem_rd`/`busy` drop asynchronously and no `done` pulse appears; after release, a new word load completes with correct latency.
- Latency sweep: MEM_LATENCY=1 and 7 -> `done` at E+2 and E+8 respectively; `ls_out` reflects `mem_data` sampled at that edge and ignores earlier values.
